serial_adder: RTL and testbench

//  Bit-serial ripple adder, the additive counterpart of the full-subtractor cell.
//  One full-adder cell plus a carry flip-flop process the operands LSB-first, one bit per clock.

---
 rtl/serial_adder.sv | 130 +++++++++++++
 tb/tb_serial_adder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder cell plus carry flop, start/done handshake.
// Optional SERIAL_ADDER_OVF_EN adds a signed-overflow output held alongside sum.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             s_bit;
    logic             c_next;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // The single full-adder cell shared by every bit position.
    always_comb begin
        s_bit  = ra_q[0] ^ rb_q[0] ^ carry_q;
        c_next = (ra_q[0] & rb_q[0]) | (ra_q[0] & carry_q) | (rb_q[0] & carry_q);
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        carry_d = carry_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        sr_d    = sr_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            SHIFT: begin
                carry_d = c_next;
                ra_d    = ra_q >> 1;
                rb_d    = rb_q >> 1;
                sr_d    = {s_bit, sr_q[WIDTH-1:1]};
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    sum_d   = {s_bit, sr_q[WIDTH-1:1]};
                    cout_d  = c_next;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q here is the carry into the MSB cell.
                    ovf_d   = carry_q ^ c_next;
`endif
                end
            end
            // DONE accepts a new start directly so back-to-back ops skip IDLE.
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = SHIFT;
                    ra_d    = a;
                    rb_d    = b;
                    carry_d = cin;
                    count_d = '0;
                    sr_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            carry_q <= 1'b0;
            ra_q    <= '0;
            rb_q    <= '0;
            sr_q    <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            carry_q <= carry_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            sr_q    <= sr_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8) with an expected-result queue popped on done.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
    logic         busy, done, cout;
    logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   cyc = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf   (ovf),
`endif
        .cout  (cout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        exp_t e;
        logic [W:0] full;
        full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        e.s = full[W-1:0];
        e.c = full[W];
        e.v = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
        return e;
    endfunction

    // Drives start for one edge; afterwards we sit 1 time unit past the accepting edge.
    task automatic do_start(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input bit push);
        a = x; b = y; cin = ci; start = 1'b1;
        if (push) exp_q.push_back(model(x, y, ci));
        step();
        start = 1'b0;
    endtask

    task automatic compare_result(input string tag);
        exp_t e;
        check({tag, "_qnonempty"}, (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_sum"}, sum, e.s);
            check({tag, "_cout"}, cout, e.c);
`ifdef SERIAL_ADDER_OVF_EN
            check({tag, "_ovf"}, ovf, e.v);
`endif
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            step();
            n++;
        end
        check({tag, "_done_seen"}, done, 1);
        if (done) compare_result(tag);
    endtask

    initial begin
        int base_cnt;
        int t_prev;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;

        // Reset state, held then released.
        step(); step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        rst = 1'b0;
        step(); step();
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_sum", sum, 0);

        // 0x3C + 0x0F with exact busy/done timing.
        do_start(8'h3C, 8'h0F, 1'b0, 1);
        a = 8'hFF; b = 8'hFF; cin = 1'b1;
        check("t1_busy_first", busy, 1);
        for (int i = 0; i < W - 1; i++) step();
        check("t1_busy_last", busy, 1);
        check("t1_done_early", done, 0);
        step();
        check("t1_done", done, 1);
        check("t1_busy_off", busy, 0);
        compare_result("t1");
        step();
        check("t1_done_pulse", done, 0);
        check("t1_sum_held", sum, 8'h4B);

        // Carry-out boundaries.
        do_start(8'hFF, 8'h01, 1'b0, 1);
        wait_done("ff_01", 20);
        step();
        do_start(8'hFF, 8'hFF, 1'b1, 1);
        wait_done("ff_ff_c", 20);
        step();

        // Start while busy is ignored.
        base_cnt = done_cnt;
        do_start(8'h10, 8'h20, 1'b0, 1);
        step(); step();
        do_start(8'hAA, 8'h55, 1'b0, 0);
        wait_done("ign", 20);
        for (int i = 0; i < 12; i++) step();
        check("ign_single_done", done_cnt - base_cnt, 1);
        check("ign_q_empty", exp_q.size(), 0);

        // Reset mid-shift aborts with no done pulse.
        base_cnt = done_cnt;
        do_start(8'h12, 8'h34, 1'b0, 0);
        step(); step(); step();
        rst = 1'b1; start = 1'b1;
        step();
        rst = 1'b0; start = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sum", sum, 0);
        check("abort_cout", cout, 0);
        for (int i = 0; i < 12; i++) step();
        check("abort_no_done", done_cnt - base_cnt, 0);
        do_start(8'h01, 8'h01, 1'b0, 1);
        wait_done("after_abort", 20);
        step();

        // Start held high: back-to-back results every W+1 cycles.
        a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
        for (int k = 0; k < 3; k++) exp_q.push_back(model(8'h80, 8'h80, 1'b0));
        t_prev = 0;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin
                wait_done("b2b", 20);
                start = 1'b0;
            end else begin
                wait_done("b2b", 20);
            end
            if (k > 0) check("b2b_period", cyc - t_prev, W + 1);
            t_prev = cyc;
            if (k < 2) step();
        end
        step();
        check("b2b_stop_busy", busy, 0);
        check("b2b_q_empty", exp_q.size(), 0);

        // Signed-overflow corner operands.
        do_start(8'h7F, 8'h01, 1'b0, 1);
        wait_done("ovf_7f_01", 20);
        step();
        do_start(8'h01, 8'h01, 1'b0, 1);
        wait_done("ovf_01_01", 20);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
